// File: rtl/spi_master_if.sv
// Bus bundle for spi_master: byte-level handshake plus the 4-wire SPI pins.
// The master modport is the design side; the slave modport is the side that
// issues bytes and models the target.
interface spi_master_if;
    logic       start;
    logic [7:0] tx_data;
    logic       last;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       SCK;
    logic       MOSI;
    logic       MISO;
    logic       SSEL;

    modport master (
        input  start, tx_data, last, MISO,
        output busy, done, rx_data, SCK, MOSI, SSEL
    );

    modport slave (
        output start, tx_data, last, MISO,
        input  busy, done, rx_data, SCK, MOSI, SSEL
    );
endinterface

// File: rtl/spi_master.sv
// spi_master: 8-bit MSB-first SPI mode-0 initiator with multi-byte SSEL hold.
// DIV sets the SCK half-period in clk cycles.
// Optional build macro SPI_MASTER_MISO_SYNC_EN: MISO goes through a 2-flop
// synchronizer and is sampled two cycles after SCK rises (requires DIV >= 3).
// Without it MISO is sampled raw on the edge that raises SCK (DIV >= 2).
module spi_master #(
    parameter int DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.master spi
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_SCK_HI = 3'd2,
        ST_SCK_LO = 3'd3,
        ST_HOLD   = 3'd4,
        ST_CLOSE  = 3'd5,
        ST_GAP    = 3'd6
    } state_t;

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       last_q, last_d;
    logic       sck_q, sck_d;
    logic       ssel_q, ssel_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       cnt_zero_s;
    logic       accept_s;
    logic       sample_now_s;
    logic       sample_bit_s;

    assign cnt_zero_s = (cnt_q == 8'd0);
    // A new byte is taken only when no byte is in flight (IDLE, or HOLD between bytes).
    assign accept_s   = spi.start && ((state_q == ST_IDLE) || (state_q == ST_HOLD));

`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int         MIN_DIV    = 3;
    // Two cycles after entering SCK_HI the counter has stepped once below its reload.
    localparam logic [7:0] SAMPLE_CNT = 8'(DIV - 2);

    logic miso_meta_q;
    logic miso_sync_q;

    // Two-flop synchronizer for the asynchronous MISO pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= spi.MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign sample_now_s = (state_q == ST_SCK_HI) && (cnt_q == SAMPLE_CNT);
    assign sample_bit_s = miso_sync_q;
`else
    localparam int MIN_DIV = 2;

    assign sample_now_s = cnt_zero_s && ((state_q == ST_SETUP) || (state_q == ST_SCK_LO));
    assign sample_bit_s = spi.MISO;
`endif

    spi_master_div_chk #(
        .DIV     (DIV),
        .MIN_DIV (MIN_DIV)
    ) u_div_chk (
        .clk (clk)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every timed state lasts DIV cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) state_d = ST_SETUP;
                else          state_d = state_q;
            end
            ST_SETUP, ST_SCK_LO: begin
                if (cnt_zero_s) state_d = ST_SCK_HI;
                else            state_d = state_q;
            end
            ST_SCK_HI: begin
                if (!cnt_zero_s)         state_d = state_q;
                else if (bit_q != 3'd7)  state_d = ST_SCK_LO;
                else if (last_q)         state_d = ST_CLOSE;
                else                     state_d = ST_HOLD;
            end
            ST_CLOSE: begin
                if (cnt_zero_s) state_d = ST_GAP;
                else            state_d = state_q;
            end
            ST_GAP: begin
                if (cnt_zero_s) state_d = ST_IDLE;
                else            state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; MOSI is the MSB of the transmit shifter.
    always_comb begin
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        last_d     = last_q;
        bit_d      = bit_q;
        sck_d      = sck_q;
        ssel_d     = ssel_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        cnt_d      = cnt_q;

        // Half-period counter reloads on every state change (SCK edges included).
        if (state_d != state_q) cnt_d = DIV_M1;
        else if (cnt_zero_s)    cnt_d = cnt_q;
        else                    cnt_d = cnt_q - 8'd1;

        if (sample_now_s) rx_shift_d = {rx_shift_q[6:0], sample_bit_s};
        else              rx_shift_d = rx_shift_q;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept_s) begin
                    tx_shift_d = spi.tx_data;
                    last_d     = spi.last;
                    ssel_d     = 1'b0;
                    busy_d     = 1'b1;
                end else begin
                    busy_d     = 1'b0;
                end
            end
            ST_SETUP, ST_SCK_LO: begin
                if (cnt_zero_s) sck_d = 1'b1;
                else            sck_d = sck_q;
            end
            ST_SCK_HI: begin
                if (cnt_zero_s) begin
                    sck_d = 1'b0;
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        done_d    = 1'b1;
                        rx_data_d = rx_shift_q;
                        busy_d    = last_q;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end else begin
                    sck_d = sck_q;
                end
            end
            ST_CLOSE: begin
                if (cnt_zero_s) ssel_d = 1'b1;
                else            ssel_d = ssel_q;
            end
            ST_GAP: begin
                if (cnt_zero_s) begin
                    busy_d     = 1'b0;
                    tx_shift_d = 8'h00;
                end else begin
                    busy_d     = busy_q;
                end
            end
            default: begin
                sck_d      = 1'b0;
                ssel_d     = 1'b1;
                busy_d     = 1'b0;
                tx_shift_d = 8'h00;
            end
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 8'd0;
            bit_q      <= 3'd0;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 8'h00;
            rx_data_q  <= 8'h00;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            sck_q      <= sck_d;
            ssel_q     <= ssel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign spi.SCK     = sck_q;
    assign spi.SSEL    = ssel_q;
    assign spi.MOSI    = tx_shift_q[7];
    assign spi.busy    = busy_q;
    assign spi.done    = done_q;
    assign spi.rx_data = rx_data_q;

endmodule

// Parameter legality checker for spi_master's SCK divider.
module spi_master_div_chk #(
    parameter int DIV     = 4,
    parameter int MIN_DIV = 2
) (
    input logic clk
);
    a_div_range: assert property (@(posedge clk) (DIV >= MIN_DIV) && (DIV <= 255));
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: randomized bytes checked cycle by cycle
// against closed-form timing (SCK phases, SSEL/busy/done windows) and a
// behavioural mode-0 target that both supplies MISO and captures MOSI.
module tb_spi_master;

`ifdef SPI_MASTER_MISO_SYNC_EN
    localparam int TB_DIV = 3;
`else
    localparam int TB_DIV = 2;
`endif

    logic clk;
    logic rst;

    spi_master_if bus ();

    spi_master #(.DIV(TB_DIV)) dut (
        .clk (clk),
        .rst (rst),
        .spi (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prev_rx;
    logic       hold_s;
    logic [7:0] last_tx;

    // Behavioural mode-0 target: presents bits MSB first, advances on SCK fall,
    // samples MOSI on SCK rise, and resynchronises whenever SSEL goes high.
    logic       loop_mode = 1'b0;
    logic [7:0] cur_resp  = 8'h00;
    logic [2:0] tgt_n     = 3'd0;
    logic [7:0] tgt_sr    = 8'h00;
    int         tgt_rn    = 0;
    logic [7:0] tgt_got_q[$];

    assign bus.MISO = loop_mode ? bus.MOSI : cur_resp[3'd7 - tgt_n];

    always @(posedge bus.SSEL or negedge bus.SCK) begin
        if (bus.SSEL) tgt_n = 3'd0;
        else          tgt_n = tgt_n + 3'd1;
    end

    always @(posedge bus.SCK or posedge bus.SSEL) begin
        if (bus.SSEL) begin
            tgt_rn = 0;
        end else begin
            tgt_sr = {tgt_sr[6:0], bus.MOSI};
            tgt_rn = tgt_rn + 1;
            if (tgt_rn == 8) begin
                tgt_got_q.push_back(tgt_sr);
                tgt_rn = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Quiet cycles between bytes: either IDLE (SSEL high) or HOLD (SSEL low).
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ssel", 32'(bus.SSEL), 32'(!hold_s));
            chk("idle_sck",  32'(bus.SCK),  32'd0);
            chk("idle_busy", 32'(bus.busy), 32'd0);
            chk("idle_done", 32'(bus.done), 32'd0);
            chk("idle_mosi", 32'(bus.MOSI), 32'(hold_s ? last_tx[0] : 1'b0));
            chk("idle_rx",   32'(bus.rx_data), 32'(prev_rx));
        end
    endtask

    // One byte: start is driven in the current cycle (cycle 0); cycle k is the
    // k-th cycle after the accepting edge. Returns at the first busy-low cycle.
    task automatic xfer(input logic [7:0] tx, input logic lst, input logic [7:0] resp,
                        input logic loop, input logic glitch);
        int         done_c;
        int         kend;
        int         rises;
        int         dones;
        int         phase;
        logic [7:0] exp_rx;
        logic       prev_sck;
        logic       exp_sck;
        done_c = 1 + 16 * TB_DIV;
        kend   = lst ? (1 + 18 * TB_DIV) : done_c;
        exp_rx = loop ? tx : resp;
        chk("pre_busy", 32'(bus.busy), 32'd0);
        loop_mode     = loop;
        cur_resp      = resp;
        bus.start     = 1'b1;
        bus.tx_data   = tx;
        bus.last      = lst;
        rises         = 0;
        dones         = 0;
        prev_sck      = bus.SCK;
        for (int k = 1; k <= kend; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (glitch && ((k == 1 + 8 * TB_DIV) || (lst && (k == done_c)))) begin
                bus.start   = 1'b1;
                bus.tx_data = 8'($urandom);
                bus.last    = 1'($urandom_range(0, 1));
            end
            phase   = (k - 1) / TB_DIV;
            exp_sck = (k < done_c) && ((phase % 2) == 1);
            chk("sck",     32'(bus.SCK),  32'(exp_sck));
            chk("ssel",    32'(bus.SSEL), 32'(lst && (k >= 1 + 17 * TB_DIV)));
            chk("busy",    32'(bus.busy), 32'(k < kend));
            chk("done",    32'(bus.done), 32'(k == done_c));
            chk("rx_data", 32'(bus.rx_data), 32'((k >= done_c) ? exp_rx : prev_rx));
            if (k < done_c)
                chk("mosi", 32'(bus.MOSI), 32'(tx[7 - (k - 1) / (2 * TB_DIV)]));
            else if (k == kend)
                chk("mosi_end", 32'(bus.MOSI), 32'(lst ? 1'b0 : tx[0]));
            if (bus.SCK && !prev_sck) rises++;
            prev_sck = bus.SCK;
            if (bus.done) dones++;
        end
        chk("sck_pulses",  32'(rises), 32'd8);
        chk("done_pulses", 32'(dones), 32'd1);
        chk("tgt_count",   32'(tgt_got_q.size()), 32'd1);
        if (tgt_got_q.size() > 0) chk("tgt_rx", 32'(tgt_got_q.pop_front()), 32'(tx));
        prev_rx = exp_rx;
        hold_s  = !lst;
        last_tx = tx;
    endtask

    // Abort a byte during its 4th SCK-high phase and check the async reset values.
    task automatic reset_mid_byte();
        loop_mode   = 1'b0;
        cur_resp    = 8'($urandom);
        bus.start   = 1'b1;
        bus.tx_data = 8'hC9;
        bus.last    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7 * TB_DIV) @(negedge clk);
        chk("pre_rst_sck", 32'(bus.SCK), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_sck",  32'(bus.SCK),  32'd0);
        chk("rst_ssel", 32'(bus.SSEL), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mosi", 32'(bus.MOSI), 32'd0);
        chk("rst_rx",   32'(bus.rx_data), 32'h00);
        @(negedge clk);
        rst     = 1'b0;
        prev_rx = 8'h00;
        hold_s  = 1'b0;
        last_tx = 8'h00;
        chk("rst_tgt_partial", 32'(tgt_got_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rtx;
        logic       rlast;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        bus.last    = 1'b0;
        prev_rx     = 8'h00;
        hold_s      = 1'b0;
        last_tx     = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_sck",  32'(bus.SCK),  32'd0);
        chk("reset_ssel", 32'(bus.SSEL), 32'd1);
        chk("reset_mosi", 32'(bus.MOSI), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rx",   32'(bus.rx_data), 32'h00);
        rst = 1'b0;
        idle(2);

        // Loopback single byte, then a target-driven exchange.
        xfer(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0);
        xfer(8'hC3, 1'b1, 8'h3C, 1'b0, 1'b0);
        idle(1);

        // Two-byte transaction issued on the first busy-low cycle.
        xfer(8'h12, 1'b0, 8'($urandom), 1'b0, 1'b0);
        xfer(8'h34, 1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(1);

        // Ignored starts mid-byte and in the done cycle of a closing byte.
        xfer(8'h96, 1'b1, 8'h69, 1'b0, 1'b1);
        xfer(8'h0F, 1'b0, 8'hE1, 1'b1, 1'b1);
        idle(2);
        xfer(8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);

        // Randomized mix of lengths, gaps, loopback and ignored starts.
        for (int i = 0; i < 24; i++) begin
            idle(int'($urandom_range(0, 3)));
            rtx   = 8'($urandom);
            rlast = (i == 23) ? 1'b1 : 1'($urandom_range(0, 1));
            xfer(rtx, rlast, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(2);

        reset_mid_byte();
        idle(2);
        xfer(8'h5A, 1'b1, 8'($urandom), 1'b0, 1'b0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
